// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex font, dark pattern and FSM states.
// Font entries are active-low, bit order g..a.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h18, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble -> active-low segment lookup using the shared hex font.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nib];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode driver: shadow-latched value, one digit lit at a time
// with an all-dark gap between digits, leading-zero suppression and global blank.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(MAXC + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0]   dp_q;
  state_e              state;
  logic [PW-1:0]       phase;
  logic [IW-1:0]       idx;

  logic [DIGITS-1:0]   sup;
  logic [3:0]          nib;
  logic                dp_sel, sup_sel, lit;
  logic [6:0]          font_seg;
  logic [DIGITS-1:0]   an_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      dp_q  <= '0;
    end else if (load) begin
      val_q <= value;
      dp_q  <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_GAP;
      phase <= '0;
      idx   <= IW'(DIGITS - 1);
    end else begin
      case (state)
        S_GAP:
          if (phase == PW'(GAP_CYCLES - 1)) begin
            phase <= '0;
            state <= S_ON;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        S_ON:
          if (phase == PW'(ON_CYCLES - 1)) begin
            phase <= '0;
            state <= S_GAP;
          end else begin
            phase <= phase + 1'b1;
          end
        default: begin
          phase <= '0;
          state <= S_GAP;
        end
      endcase
    end
  end

  // Digit i is a leading zero when it and every more-significant nibble are 0;
  // digit 0 always shows so that a zero value still reads "0".
  assign sup[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_sup
    assign sup[i] = lz_en & ~|val_q[4*DIGITS-1:4*i];
  end

  always_comb begin
    nib     = '0;
    dp_sel  = 1'b0;
    sup_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib     = val_q[4*i +: 4];
        dp_sel  = dp_q[i];
        sup_sel = sup[i];
      end
    end
  end

  hex_to_7seg u_font (
    .nib (nib),
    .seg (font_seg)
  );

  assign lit = (state == S_ON) && !blank && !sup_sel;

  for (genvar i = 0; i < DIGITS; i++) begin : g_an
    assign an_d[i] = !(lit && (idx == IW'(i)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= lit ? font_seg : SEG_OFF;
      dp  <= lit ? ~dp_sel : 1'b1;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized + directed bench for seven_seg_scan_driver against a slot-arithmetic reference model.
module tb_seven_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int ON_C   = 4;
  localparam int GAP_C  = 2;
  localparam int SLOT   = ON_C + GAP_C;

  logic                clk;
  logic                reset;
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic                blank;
  logic                lz_en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] font_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_scan_driver #(
    .DIGITS     (DIGITS),
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .dp_in (dp_in),
    .blank (blank),
    .lz_en (lz_en),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: after c edges since release the scan sits at slot (c/SLOT)%DIGITS,
  // lit only in the last ON_C cycles of each slot.
  function automatic logic [11:0] ref_out(input int c, input logic [15:0] v, input logic [3:0] d,
                                          input logic bl, input logic lz);
    int          pos, dig;
    logic        on, sup, lit;
    logic [15:0] hi;
    logic [3:0]  nb;
    logic [3:0]  an_e;
    pos = c % SLOT;
    dig = (c / SLOT) % DIGITS;
    on  = (pos >= GAP_C);
    hi  = v >> (4 * dig);
    nb  = hi[3:0];
    sup = lz && (dig != 0) && (hi == 16'h0);
    lit = on && !bl && !sup;
    an_e = 4'hF;
    if (lit) an_e[dig] = 1'b0;
    return lit ? {font_ref[nb], ~d[dig], an_e} : {7'h7F, 1'b1, 4'hF};
  endfunction

  int          cnt;
  logic [15:0] mval;
  logic [3:0]  mdp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 0;
      mval  <= '0;
      mdp   <= '0;
      e_seg <= 7'h7F;
      e_dp  <= 1'b1;
      e_an  <= 4'hF;
    end else begin
      {e_seg, e_dp, e_an} <= ref_out(cnt, mval, mdp, blank, lz_en);
      cnt <= cnt + 1;
      if (load) begin
        mval <= value;
        mdp  <= dp_in;
      end
    end
  end

  always @(negedge clk) begin
    chk("seg", {25'b0, seg}, {25'b0, e_seg});
    chk("dp",  {31'b0, dp},  {31'b0, e_dp});
    chk("an",  {28'b0, an},  {28'b0, e_an});
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ld(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Wait (bounded) until the model is about to spend a cycle in slot s at position p.
  task automatic wait_slot(input int s, input int p, input string tag);
    int k;
    k = 0;
    while (!((cnt % SLOT == p) && ((cnt / SLOT) % DIGITS == s)) && k < 4 * SLOT * DIGITS) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reached"}, (k < 4 * SLOT * DIGITS) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    blank = 1'b0;
    lz_en = 1'b0;
    run(3);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_an",  {28'b0, an},  32'hF);
    reset = 1'b1;
    run(2 * SLOT * DIGITS);

    ld(16'h0123, 4'h0); run(SLOT * DIGITS + 2);
    ld(16'h4567, 4'h0); run(SLOT * DIGITS + 2);
    ld(16'h89AB, 4'h0); run(SLOT * DIGITS + 2);
    ld(16'hCDEF, 4'h0); run(SLOT * DIGITS + 2);

    lz_en = 1'b1;
    ld(16'h0050, 4'h0); run(SLOT * DIGITS + 2);
    lz_en = 1'b0;       run(SLOT * DIGITS);
    lz_en = 1'b1;
    ld(16'h0000, 4'h0); run(SLOT * DIGITS + 2);
    lz_en = 1'b0;

    ld(16'h1234, 4'b0100); run(SLOT * DIGITS + 2);
    wait_slot(1, GAP_C + 1, "blank");
    blank = 1'b1; run(10);
    blank = 1'b0; run(SLOT * DIGITS);

    wait_slot(1, SLOT - 1, "ld_trans");
    ld(16'h1111, 4'h0);
    run(SLOT);
    wait_slot(2, GAP_C + 1, "mid_rst");
    #2 reset = 1'b0;
    #1;
    chk("arst_seg", {25'b0, seg}, 32'h7F);
    chk("arst_dp",  {31'b0, dp},  32'h1);
    chk("arst_an",  {28'b0, an},  32'hF);
    @(negedge clk);
    reset = 1'b1;
    run(2 * SLOT * DIGITS);

    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom % 8 == 0);
      value = 16'($urandom) >> $urandom_range(0, 16);
      dp_in = 4'($urandom);
      blank = ($urandom % 16 == 0);
      if ($urandom % 64 == 0) lz_en = ~lz_en;
      @(negedge clk);
    end
    load  = 1'b0;
    blank = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
